// File: rtl/half_adder_unit.sv
// Per-lane half adder with a zero-latency result, a one-cycle registered result
// with valid flag, and a saturating count of samples that produced any carry.
module half_adder_unit #(
  parameter int WIDTH   = 1,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   s,
  output logic [WIDTH-1:0]   c,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   s_q,
  output logic [WIDTH-1:0]   c_q,
  output logic               out_valid,
  input  logic               clr_cnt,
  output logic [COUNT_W-1:0] carry_cnt,
  output logic               cnt_sat
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   carry_s;
  logic               any_carry_s;
  logic [COUNT_W-1:0] cnt_next_s;

  logic [WIDTH-1:0]   sum_r;
  logic [WIDTH-1:0]   carry_r;
  logic               valid_r;
  logic [COUNT_W-1:0] cnt_r;

  // Lane-wise half adder; lanes never interact, so no carry chain exists.
  always_comb begin
    sum_s       = a ^ b;
    carry_s     = a & b;
    any_carry_s = |carry_s;
  end

  // Counter next state: clear beats a simultaneous event, and the count sticks at max.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr_cnt) begin
      cnt_next_s = '0;
    end else if (in_valid && any_carry_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Registered result, valid flag and counter; results hold when no valid sample arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= '0;
      valid_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      if (in_valid) begin
        sum_r   <= sum_s;
        carry_r <= carry_s;
      end else begin
        sum_r   <= sum_r;
        carry_r <= carry_r;
      end
      valid_r <= in_valid;
      cnt_r   <= cnt_next_s;
    end
  end

  assign s         = sum_s;
  assign c         = carry_s;
  assign s_q       = sum_r;
  assign c_q       = carry_r;
  assign out_valid = valid_r;
  assign carry_cnt = cnt_r;
  assign cnt_sat   = (cnt_r == CNT_MAX);

endmodule

// File: tb/tb_half_adder_unit.sv
// Directed and randomized checks of half_adder_unit across three parameterizations
// against an arithmetic reference model.
module tb_half_adder_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // instance 1: WIDTH=1, COUNT_W=8
  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0, clr1 = 1'b0;
  logic s1, c1, sq1, cq1, ov1, sat1;
  logic [7:0] cnt1;
  // instance 2: WIDTH=1, COUNT_W=2
  logic a2 = 1'b0, b2 = 1'b0, v2 = 1'b0, clr2 = 1'b0;
  logic s2, c2, sq2, cq2, ov2, sat2;
  logic [1:0] cnt2;
  // instance 3: WIDTH=4, COUNT_W=4
  logic [3:0] a3 = 4'd0, b3 = 4'd0;
  logic v3 = 1'b0, clr3 = 1'b0;
  logic [3:0] s3, c3, sq3, cq3;
  logic ov3, sat3;
  logic [3:0] cnt3;

  half_adder_unit #(.WIDTH(1), .COUNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .s(s1), .c(c1), .in_valid(v1),
    .s_q(sq1), .c_q(cq1), .out_valid(ov1), .clr_cnt(clr1), .carry_cnt(cnt1), .cnt_sat(sat1));

  half_adder_unit #(.WIDTH(1), .COUNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .s(s2), .c(c2), .in_valid(v2),
    .s_q(sq2), .c_q(cq2), .out_valid(ov2), .clr_cnt(clr2), .carry_cnt(cnt2), .cnt_sat(sat2));

  half_adder_unit #(.WIDTH(4), .COUNT_W(4)) u_w4 (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .s(s3), .c(c3), .in_valid(v3),
    .s_q(sq3), .c_q(cq3), .out_valid(ov3), .clr_cnt(clr3), .carry_cnt(cnt3), .cnt_sat(sat3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each lane adds two bits as integers; low bit is sum, high bit is carry.
  function automatic logic [7:0] ref_add(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] rs;
    logic [3:0] rc;
    int t;
    rs = 4'd0;
    rc = 4'd0;
    for (int i = 0; i < 4; i++) begin
      t = int'(x[i]) + int'(y[i]);
      rs[i] = (t % 2) == 1;
      rc[i] = (t / 2) == 1;
    end
    return {rs, rc};
  endfunction

  logic [1:0] vec_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] vec_sc [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

  initial begin
    logic [3:0] ra, rb, esq, ecq;
    logic [7:0] r;
    logic rv, rclr, eov;
    int ecnt;

    #1;
    check("rst_s_q", 32'(sq1), 32'd0);
    check("rst_c_q", 32'(cq1), 32'd0);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_carry_cnt", 32'(cnt1), 32'd0);
    check("rst_cnt_sat", 32'(sat1), 32'd0);

    // combinational truth table while held in reset
    for (int k = 0; k < 4; k++) begin
      a1 = vec_ab[k][1];
      b1 = vec_ab[k][0];
      #100;
      check("comb_sc", 32'({s1, c1}), 32'(vec_sc[k]));
    end
    check("comb_rst_ov", 32'(ov1), 32'd0);

    // lane independence on the 4-bit instance
    a3 = 4'b1011;
    b3 = 4'b0110;
    #1;
    check("lane_s", 32'(s3), 32'b1101);
    check("lane_c", 32'(c3), 32'b0010);
    a3 = 4'd0;
    b3 = 4'd0;

    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    step();
    check("lat_s_q", 32'(sq1), 32'd0);
    check("lat_c_q", 32'(cq1), 32'd1);
    check("lat_out_valid", 32'(ov1), 32'd1);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    step();
    check("hold_out_valid", 32'(ov1), 32'd0);
    check("hold_s_q", 32'(sq1), 32'd0);
    check("hold_c_q", 32'(cq1), 32'd1);
    check("hold_cnt", 32'(cnt1), 32'd1);

    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    check("clr_cnt1", 32'(cnt1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      a1 = vec_ab[k][1]; b1 = vec_ab[k][0]; v1 = 1'b1;
      step();
    end
    check("cnt_last_s_q", 32'(sq1), 32'd0);
    check("cnt_last_c_q", 32'(cq1), 32'd1);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
    step();
    step();
    check("cnt_one", 32'(cnt1), 32'd1);

    // saturation on the 2-bit counter
    a2 = 1'b1; b2 = 1'b1; v2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) check("sat_not_yet", 32'(sat2), 32'd0);
    end
    check("sat_cnt", 32'(cnt2), 32'd3);
    check("sat_flag", 32'(sat2), 32'd1);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0; v2 = 1'b0;
    check("clr_prio_cnt", 32'(cnt2), 32'd0);
    check("clr_prio_sat", 32'(sat2), 32'd0);

    // async reset mid-stream with count 2 and a valid result pending
    clr1 = 1'b1; v1 = 1'b0;
    step();
    clr1 = 1'b0; a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    step();
    step();
    check("pre_rst_cnt", 32'(cnt1), 32'd2);
    check("pre_rst_ov", 32'(ov1), 32'd1);
    #2;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    #1;
    check("arst_s_q", 32'(sq1), 32'd0);
    check("arst_c_q", 32'(cq1), 32'd0);
    check("arst_ov", 32'(ov1), 32'd0);
    check("arst_cnt", 32'(cnt1), 32'd0);
    check("arst_comb_s", 32'(s1), 32'd1);
    check("arst_comb_c", 32'(c1), 32'd0);
    rst = 1'b0;
    v1 = 1'b0;
    #1;
    check("arst_hold_ov", 32'(ov1), 32'd0);
    step();

    // randomized traffic on the 4-lane instance
    esq = 4'd0; ecq = 4'd0; eov = 1'b0; ecnt = 0;
    check("w4_rst_cnt", 32'(cnt3), 32'd0);
    for (int k = 0; k < 300; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 3) != 0);
      rclr = ($urandom_range(0, 15) == 0);
      a3 = ra; b3 = rb; v3 = rv; clr3 = rclr;
      #1;
      r = ref_add(ra, rb);
      check("rnd_s", 32'(s3), 32'(r[7:4]));
      check("rnd_c", 32'(c3), 32'(r[3:0]));
      step();
      if (rv) begin
        esq = r[7:4];
        ecq = r[3:0];
      end
      eov = rv;
      if (rclr) ecnt = 0;
      else if (rv && (r[3:0] != 4'd0) && (ecnt < 15)) ecnt = ecnt + 1;
      check("rnd_s_q", 32'(sq3), 32'(esq));
      check("rnd_c_q", 32'(cq3), 32'(ecq));
      check("rnd_ov", 32'(ov3), 32'(eov));
      check("rnd_cnt", 32'(cnt3), 32'(ecnt));
      check("rnd_sat", 32'(sat3), (ecnt == 15) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
